// File: rtl/bus_write_demux_pkg.sv
// Shared core definitions: bus width, destination/source codes, write FSM states.
package bus_write_demux_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned DEST_W   = 4;
  localparam int unsigned NUM_DEST = 16;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned NUM_RF   = 10;

  // Destination codes; identical numbering to the bus source selector
  localparam logic [DEST_W-1:0] DEST_NONE = 4'd0;
  localparam logic [DEST_W-1:0] DEST_AC   = 4'd1;
  localparam logic [DEST_W-1:0] DEST_DR   = 4'd2;
  localparam logic [DEST_W-1:0] DEST_R1   = 4'd3;
  localparam logic [DEST_W-1:0] DEST_R2   = 4'd4;
  localparam logic [DEST_W-1:0] DEST_R3   = 4'd5;
  localparam logic [DEST_W-1:0] DEST_R4   = 4'd6;
  localparam logic [DEST_W-1:0] DEST_R5   = 4'd7;
  localparam logic [DEST_W-1:0] DEST_R6   = 4'd8;
  localparam logic [DEST_W-1:0] DEST_R7   = 4'd9;
  localparam logic [DEST_W-1:0] DEST_R8   = 4'd10;
  localparam logic [DEST_W-1:0] DEST_R9   = 4'd11;
  localparam logic [DEST_W-1:0] DEST_R10  = 4'd12;
  localparam logic [DEST_W-1:0] DEST_DM   = 4'd13;
  localparam logic [DEST_W-1:0] DEST_IM   = 4'd14;
  localparam logic [DEST_W-1:0] DEST_AR   = 4'd15;

  // Destinations that are plain registers loaded in a single cycle (1..12, 15)
  localparam logic [NUM_DEST-1:0] DEST_REG_MASK = 16'h9FFE;

  // Memory write port states
  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MEM_WAIT = 1'b1
  } wr_state_e;

  // One-hot decode of a destination code
  function automatic logic [NUM_DEST-1:0] dest_onehot(input logic [DEST_W-1:0] d);
    return NUM_DEST'(1) << d;
  endfunction

endpackage

// File: rtl/bus_write_demux_mem_write_port.sv
// Request/acknowledge memory write engine with saturating timeout counter.
module mem_write_port #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_sel,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_mem_ack,
  output logic              o_ready,
  output logic              o_mem_wr_en,
  output logic              o_mem_sel,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_done_c,
  output logic              o_timeout_c
);

  import bus_write_demux_pkg::*;

  // Last wait cycle: the edge on which the counter would reach TIMEOUT
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);

  wr_state_e         r_state;
  wr_state_e         w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_ready;
  logic              r_mem_wr_en;
  logic              r_mem_sel;
  logic [DATA_W-1:0] r_mem_wdata;

  // Next-state, counter and completion events; ack takes priority over timeout
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_done_c    = 1'b0;
    o_timeout_c = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_MEM_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (r_cnt != CNT_SAT) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
        if (i_mem_ack) begin
          o_done_c    = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          o_timeout_c = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counter and state-derived handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_ready     <= 1'b1;
      r_mem_wr_en <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ready     <= (w_state_nxt == ST_IDLE);
      r_mem_wr_en <= (w_state_nxt == ST_MEM_WAIT);
    end
  end

  // Write data and target latches, captured only when a transaction starts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_sel   <= 1'b0;
      r_mem_wdata <= '0;
    end else if ((r_state == ST_IDLE) && i_start) begin
      r_mem_sel   <= i_sel;
      r_mem_wdata <= i_wdata;
    end
  end

  assign o_ready     = r_ready;
  assign o_mem_wr_en = r_mem_wr_en;
  assign o_mem_sel   = r_mem_sel;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: rtl/bus_write_demux.sv
// Core bus write-side demux: loads the addressed register or runs a memory write.
module bus_write_demux #(
  parameter int unsigned DATA_W  = bus_write_demux_pkg::DATA_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] bus_in,
  input  logic [3:0]        dest,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] ac_out,
  output logic [DATA_W-1:0] dr_out,
  output logic [DATA_W-1:0] ar_out,
  output logic [DATA_W-1:0] r1_out,
  output logic [DATA_W-1:0] r2_out,
  output logic [DATA_W-1:0] r3_out,
  output logic [DATA_W-1:0] r4_out,
  output logic [DATA_W-1:0] r5_out,
  output logic [DATA_W-1:0] r6_out,
  output logic [DATA_W-1:0] r7_out,
  output logic [DATA_W-1:0] r8_out,
  output logic [DATA_W-1:0] r9_out,
  output logic [DATA_W-1:0] r10_out,
  output logic [15:0]       ld_strobe,
  output logic              mem_wr_en,
  output logic              mem_sel,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  output logic              err
);

  import bus_write_demux_pkg::*;

  logic                w_ready;
  logic                w_accept;
  logic [NUM_DEST-1:0] w_load;
  logic                w_mem_start;
  logic                w_mem_sel;
  logic                w_mem_done;
  logic                w_mem_timeout;
  logic [NUM_DEST-1:0] w_strobe_nxt;
  logic                w_err_nxt;

  logic [DATA_W-1:0]   r_ac;
  logic [DATA_W-1:0]   r_dr;
  logic [DATA_W-1:0]   r_ar;
  logic [DATA_W-1:0]   r_rf [NUM_RF];
  logic [NUM_DEST-1:0] r_ld_strobe;
  logic                r_err;

  // Request handshake and one-hot destination decode
  assign w_accept    = wr_valid & w_ready;
  assign w_load      = w_accept ? dest_onehot(dest) : '0;
  assign w_mem_start = w_load[DEST_DM] | w_load[DEST_IM];

  // Memory destinations go through the request/acknowledge engine
  mem_write_port #(
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) u_mem_write_port (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_mem_start),
    .i_sel       (dest == DEST_IM),
    .i_wdata     (bus_in),
    .i_mem_ack   (mem_ack),
    .o_ready     (w_ready),
    .o_mem_wr_en (mem_wr_en),
    .o_mem_sel   (w_mem_sel),
    .o_mem_wdata (mem_wdata),
    .o_done_c    (w_mem_done),
    .o_timeout_c (w_mem_timeout)
  );

  // Named single registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ac <= '0;
      r_dr <= '0;
      r_ar <= '0;
    end else begin
      if (w_load[DEST_AC]) r_ac <= bus_in;
      if (w_load[DEST_DR]) r_dr <= bus_in;
      if (w_load[DEST_AR]) r_ar <= bus_in;
    end
  end

  // General registers r1..r10 occupy consecutive codes starting at DEST_R1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_RF; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_RF; i++) begin
        if (w_load[int'(DEST_R1) + i]) r_rf[i] <= bus_in;
      end
    end
  end

  // Load strobes and error pulse for the cycle following the triggering edge
  always_comb begin
    w_strobe_nxt = w_load & DEST_REG_MASK;
    w_err_nxt    = w_load[DEST_NONE] | w_mem_timeout;
    if (w_mem_done) begin
      w_strobe_nxt[w_mem_sel ? DEST_IM : DEST_DM] = 1'b1;
    end
  end

  // Register the one-cycle pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ld_strobe <= '0;
      r_err       <= 1'b0;
    end else begin
      r_ld_strobe <= w_strobe_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign wr_ready  = w_ready;
  assign mem_sel   = w_mem_sel;
  assign ld_strobe = r_ld_strobe;
  assign err       = r_err;
  assign ac_out    = r_ac;
  assign dr_out    = r_dr;
  assign ar_out    = r_ar;
  assign r1_out    = r_rf[0];
  assign r2_out    = r_rf[1];
  assign r3_out    = r_rf[2];
  assign r4_out    = r_rf[3];
  assign r5_out    = r_rf[4];
  assign r6_out    = r_rf[5];
  assign r7_out    = r_rf[6];
  assign r8_out    = r_rf[7];
  assign r9_out    = r_rf[8];
  assign r10_out   = r_rf[9];

endmodule

// File: doc/bus_write_demux.md
# bus_write_demux

Write-side counterpart of the shared 16-bit core data bus. Every transfer on the bus is driven by a 4-bit source selector. This block takes the bus value together with a 4-bit destination code, using the same numbering as the source selector, and loads it into the addressed core register. For memory destinations it runs a request/acknowledge write cycle with timeout. One instance sits in each core, next to the bus source mux.

## Interface
Parameters:
- DATA_W, 16, bus and register width
- TIMEOUT, 255, maximum cycles spent waiting for `mem_ack` before abort (8-bit counter)

Ports:
- clk  input  1  core clock; all state changes on rising edge
- rst  input  1  reset, asynchronous and active-low (asserted when 0)
- bus_in  input  DATA_W  current value of the shared core bus
- dest  input  4  destination code: 0 none, 1 ac, 2 dr, 3..12 r1..r10, 13 dm, 14 im, 15 ar
- wr_valid  input  1  write request; `bus_in` and `dest` are valid while high
- wr_ready  output  1  block can accept a request this cycle
- ac_out, dr_out, ar_out, r1_out..r10_out  output  DATA_W each  register contents
- ld_strobe  output  16  one-hot, one-cycle pulse; bit n set means destination n was loaded on the previous edge
- mem_wr_en  output  1  memory write request, held until acknowledged or timed out
- mem_sel  output  1  0 = data memory, 1 = instruction memory
- mem_wdata  output  DATA_W  latched write data
- mem_ack  input  1  memory write complete
- err  output  1  one-cycle pulse on illegal destination or timeout

## Operation
- FSM states: IDLE and MEM_WAIT.
- IDLE:
  - `wr_ready` = 1.
  - A request is accepted on a rising edge where `wr_valid` and `wr_ready` are both 1.
- Register destinations (1..12, 15):
  - The addressed register is loaded from `bus_in` on the accept edge.
  - `ld_strobe[dest]` is 1 for the following cycle.
  - The FSM stays in IDLE, so back-to-back writes are possible every cycle.
- Memory destinations (13, 14):
  - On the accept edge, `bus_in` is latched into `mem_wdata` and `mem_sel` is set to `dest == 14`.
  - The timeout counter is cleared and the FSM moves to MEM_WAIT.
- Destination 0:
  - Nothing is written.
  - `err` pulses for one cycle and the FSM stays in IDLE.
- MEM_WAIT:
  - `wr_ready` = 0 and `mem_wr_en` = 1.
  - `mem_wdata` and `mem_sel` are held stable.
  - The counter increments each cycle.
  - `mem_ack` = 1: return to IDLE and pulse `ld_strobe[13 or 14]` in the next cycle.
  - Counter reaches TIMEOUT with no ack: return to IDLE and pulse `err`; the write is dropped.
  - If `mem_ack` arrives on the same edge the counter reaches TIMEOUT, the ack wins (success, no `err`).
- `mem_ack` seen while in IDLE is ignored.
- `wr_valid` seen during MEM_WAIT is not accepted. The requester must hold the request until `wr_ready` returns.

## Timing
- Reset (rst = 0, asynchronous):
  - All registers and `mem_wdata` are cleared to 0.
  - `ld_strobe`, `err`, `mem_wr_en` and `mem_sel` are cleared to 0.
  - `wr_ready` = 1 and the FSM is in IDLE.
- Reset mid-MEM_WAIT aborts the write immediately: `mem_wr_en` drops with no edge required.
- Register write latency: the register value is visible 1 cycle after the accept edge, coincident with `ld_strobe`.
- Memory write timing:
  - `mem_wr_en` rises in the cycle after accept.
  - It falls in the cycle after the edge that samples `mem_ack`.
  - `wr_ready` returns in that same cycle.
- Minimum memory transaction, ack on the first MEM_WAIT cycle: 2 cycles accept-to-ready.
- `wr_ready` is a registered output (it depends on state only), never combinationally on `wr_valid`.
- No arithmetic on data; the counter is 8-bit and saturates at TIMEOUT.

## Structure
- Shared core package holds:
  - the destination code constants (DEST_NONE, DEST_AC, DEST_DR, DEST_R1..DEST_R10, DEST_DM, DEST_IM, DEST_AR), one set shared with the bus source mux encoding;
  - the FSM state typedef;
  - DATA_W.
- One natural sub-module: `mem_write_port`, containing the MEM_WAIT FSM, timeout counter, and `mem_wdata`/`mem_sel` latches. The register bank and decode stay in the top level.

## Test plan
- Reset then write: rst low → all outputs 0 and `wr_ready` = 1. Write 0x1234 to dest 5 → `r3_out` = 0x1234 one cycle later, `ld_strobe` = 0x0020 for one cycle.
- Back-to-back writes: dest 2, 3, 15 with data 0xAAAA, 0x5555, 0x00FF on consecutive cycles → `dr_out`, `r1_out`, `ar_out` loaded in order; `wr_ready` never drops.
- Data memory write: dest 13 with data 0xBEEF, `mem_ack` after 3 cycles → `mem_wr_en` high for 3 cycles, `mem_wdata` = 0xBEEF, `mem_sel` = 0; then `ld_strobe` = 0x2000 and `wr_ready` = 1.
- Timeout and simultaneous ack:
  - dest 14 with no ack → `err` pulses after TIMEOUT cycles, `mem_wr_en` drops, no registers change.
  - Repeat with ack on the TIMEOUT edge → success, no `err`.
- Illegal destination and blocked request:
  - dest 0 → `err` pulse, no load.
  - `wr_valid` held during MEM_WAIT with dest 4 → `r2_out` updates only after `wr_ready` returns.
- Reset mid-transaction: rst low during MEM_WAIT → `mem_wr_en` = 0 immediately; after release, FSM in IDLE and a stray `mem_ack` has no effect.
